// File: rtl/ula_16_bits_seq.sv
// 16-bit ALU built from one 8-bit ALU that is time-shared over a low-byte pass
// and a high-byte pass, with the carry chained between the two passes.

module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       overflow,
  output logic       a_eq_b
);

  logic [7:0] x, y, lg;
  logic [8:0] sum;

  // Arithmetic results are always X + Y + c_in.
  // The carry is produced in both modes so that the pass chain stays live.
  always_comb begin
    x = a;
    y = 8'h00;
    unique case (s)
      4'b0000: begin x = a;       y = 8'h00;  end
      4'b0001: begin x = a | b;   y = 8'h00;  end
      4'b0010: begin x = a & b;   y = 8'h00;  end
      4'b0011: begin x = 8'hFF;   y = 8'h00;  end
      4'b0100: begin x = a;       y = a & ~b; end
      4'b0101: begin x = a;       y = b;      end
      4'b0110: begin x = a;       y = ~b;     end
      4'b0111: begin x = a & ~b;  y = 8'hFF;  end
      4'b1000: begin x = a;       y = a & b;  end
      4'b1001: begin x = a;       y = a;      end
      4'b1010: begin x = a | b;   y = a & ~b; end
      4'b1011: begin x = a & b;   y = 8'hFF;  end
      4'b1100: begin x = a | ~b;  y = a;      end
      4'b1101: begin x = a | b;   y = a;      end
      4'b1110: begin x = a;       y = 8'hFF;  end
      4'b1111: begin x = b;       y = 8'h00;  end
    endcase
  end

  always_comb begin
    lg = 8'h00;
    unique case (s)
      4'b0000: lg = ~a;
      4'b0001: lg = ~(a | b);
      4'b0010: lg = ~a & b;
      4'b0011: lg = 8'h00;
      4'b0100: lg = ~(a & b);
      4'b0101: lg = ~b;
      4'b0110: lg = a ^ b;
      4'b0111: lg = a & ~b;
      4'b1000: lg = ~a | b;
      4'b1001: lg = ~(a ^ b);
      4'b1010: lg = b;
      4'b1011: lg = a & b;
      4'b1100: lg = 8'hFF;
      4'b1101: lg = a | ~b;
      4'b1110: lg = a | b;
      4'b1111: lg = a;
    endcase
  end

  assign sum      = {1'b0, x} + {1'b0, y} + {8'h00, c_in};
  assign f        = m ? lg : sum[7:0];
  assign c_out    = sum[8];
  assign overflow = (x[7] == y[7]) && (sum[7] != x[7]);
  assign a_eq_b   = (a == b);

endmodule

module ula_16_bits_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  input  logic        m,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] f,
  output logic        c_out,
  output logic        overflow,
  output logic        a_eq_b
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, b_q;
  logic [3:0]  s_q;
  logic        m_q, c_in_q;
  logic        c_low_q, eq_low_q;

  logic [7:0]  alu_a, alu_b, alu_f;
  logic        alu_cin, alu_cout, alu_ovf, alu_eq;

  logic        high_pass;
  assign high_pass = (state_q == StHigh);

  assign alu_a   = high_pass ? a_q[15:8] : a_q[7:0];
  assign alu_b   = high_pass ? b_q[15:8] : b_q[7:0];
  assign alu_cin = high_pass ? c_low_q   : c_in_q;

  ula_8_bits u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .s        (s_q),
    .m        (m_q),
    .c_in     (alu_cin),
    .f        (alu_f),
    .c_out    (alu_cout),
    .overflow (alu_ovf),
    .a_eq_b   (alu_eq)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLow;
      StLow:  state_d = StHigh;
      StHigh: state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      c_in_q   <= 1'b0;
      c_low_q  <= 1'b0;
      eq_low_q <= 1'b0;
      f        <= 16'h0000;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      a_eq_b   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            s_q    <= s;
            m_q    <= m;
            c_in_q <= c_in;
          end
        end
        StLow: begin
          f[7:0]   <= alu_f;
          c_low_q  <= alu_cout;
          eq_low_q <= alu_eq;
        end
        StHigh: begin
          // Low-pass overflow is intentionally dropped; flags describe the full word.
          f[15:8]  <= alu_f;
          c_out    <= alu_cout;
          overflow <= alu_ovf;
          a_eq_b   <= eq_low_q & alu_eq;
        end
        StDone: ;
      endcase
    end
  end

  assign busy = (state_q == StLow) || (state_q == StHigh);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_ula_16_bits_seq.sv
// Directed bench for the byte-sequential 16-bit ALU: timing, chaining, flags,
// restart immunity and mid-operation reset.

module tb_ula_16_bits_seq;

  logic        clk, rst, start, m, c_in;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        busy, done, c_out, overflow, a_eq_b;
  logic [15:0] f;

  int vectors = 0;
  int miscompares = 0;

  ula_16_bits_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .s        (s),
    .m        (m),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .f        (f),
    .c_out    (c_out),
    .overflow (overflow),
    .a_eq_b   (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns just after the accepting rising edge with
  // the inputs scrambled so late changes would corrupt the result.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                       input logic tm, input logic tc);
    a = ta; b = tb; s = ts; m = tm; c_in = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
    m = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic observe(input int n, output int bc, output int dc, output int dcy);
    bc = 0; dc = 0; dcy = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin dc++; dcy = i; end
    end
  endtask

  task automatic test_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (f !== 16'h0000) begin miscompares++; $display("FAIL reset_f: got %h expected 0000", f); end
    vectors++; if ({c_out, overflow, a_eq_b} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {c_out, overflow, a_eq_b});
    end
  endtask

  task automatic test_add_chain();
    int bc, dc, dcy;
    issue(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    observe(5, bc, dc, dcy);
    vectors++; if (f !== 16'h0100) begin miscompares++; $display("FAIL chain_f: got %h expected 0100", f); end
    vectors++; if ({c_out, overflow} !== 2'b00) begin
      miscompares++; $display("FAIL chain_flags: got %b expected 00", {c_out, overflow});
    end
    vectors++; if (dcy !== 3) begin miscompares++; $display("FAIL chain_latency: got %0d expected 3", dcy); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL chain_done_count: got %0d expected 1", dc); end
    vectors++; if (bc !== 2) begin miscompares++; $display("FAIL chain_busy_cycles: got %0d expected 2", bc); end
  endtask

  task automatic test_hold();
    issue(16'h1234, 16'h1111, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (f !== 16'h0100) begin miscompares++; $display("FAIL hold_before_low: got %h expected 0100", f); end
    @(negedge clk);
    vectors++; if (f !== 16'h0145) begin miscompares++; $display("FAIL hold_after_low: got %h expected 0145", f); end
    @(negedge clk);
    vectors++; if ({done, f} !== {1'b1, 16'h2345}) begin
      miscompares++; $display("FAIL hold_done: got %b/%h expected 1/2345", done, f);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++; if ({done, f} !== {1'b0, 16'h2345}) begin
      miscompares++; $display("FAIL hold_idle: got %b/%h expected 0/2345", done, f);
    end
  endtask

  task automatic test_busy_restart();
    int bc = 0, dc = 0, dcy = 0;
    issue(16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin dc++; dcy = i; end
      if (i == 1 || i == 3) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
      else start = 1'b0;
    end
    vectors++; if (f !== 16'h0100) begin miscompares++; $display("FAIL restart_f: got %h expected 0100", f); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL restart_done_count: got %0d expected 1", dc); end
    vectors++; if (dcy !== 3) begin miscompares++; $display("FAIL restart_latency: got %0d expected 3", dcy); end
    vectors++; if (bc !== 2) begin miscompares++; $display("FAIL restart_busy: got %0d expected 2", bc); end
  endtask

  task automatic test_overflow();
    int bc, dc, dcy;
    issue(16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if ({f, c_out, overflow} !== {16'h8000, 2'b01}) begin
      miscompares++; $display("FAIL ovf_pos: got %h c%b v%b expected 8000 c0 v1", f, c_out, overflow);
    end
    issue(16'hFFFF, 16'h0001, 4'b0101, 1'b0, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if ({f, c_out, overflow} !== {16'h0000, 2'b10}) begin
      miscompares++; $display("FAIL ovf_carry: got %h c%b v%b expected 0000 c1 v0", f, c_out, overflow);
    end
  endtask

  task automatic test_logic();
    int bc, dc, dcy;
    issue(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if (f !== 16'h0FF0) begin miscompares++; $display("FAIL logic_xor: got %h expected 0FF0", f); end
    issue(16'h1234, 16'h0F0F, 4'b1011, 1'b1, 1'b1);
    observe(4, bc, dc, dcy);
    vectors++; if (f !== 16'h0204) begin miscompares++; $display("FAIL logic_and: got %h expected 0204", f); end
    issue(16'h1234, 16'h00FF, 4'b0101, 1'b1, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if (f !== 16'hFF00) begin miscompares++; $display("FAIL logic_notb: got %h expected FF00", f); end
  endtask

  task automatic test_equality();
    int bc, dc, dcy;
    issue(16'h5555, 16'hD555, 4'b1000, 1'b0, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if (a_eq_b !== 1'b0) begin miscompares++; $display("FAIL eq_high_diff: got %b expected 0", a_eq_b); end
    issue(16'h5555, 16'h5554, 4'b1000, 1'b0, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if (a_eq_b !== 1'b0) begin miscompares++; $display("FAIL eq_low_diff: got %b expected 0", a_eq_b); end
    issue(16'h5555, 16'h5555, 4'b1000, 1'b0, 1'b0);
    observe(4, bc, dc, dcy);
    vectors++; if (a_eq_b !== 1'b1) begin miscompares++; $display("FAIL eq_same: got %b expected 1", a_eq_b); end
    vectors++; if ({f, overflow} !== {16'hAAAA, 1'b1}) begin
      miscompares++; $display("FAIL eq_same_f: got %h v%b expected AAAA v1", f, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, dcy;
    issue(16'h5555, 16'h5555, 4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL midrst_ctrl: got %b expected 00", {busy, done});
    end
    vectors++; if ({f, c_out, overflow, a_eq_b} !== 19'h0) begin
      miscompares++; $display("FAIL midrst_out: got %h %b expected 0000 000", f, {c_out, overflow, a_eq_b});
    end
    observe(3, bc, dc, dcy);
    vectors++; if (dc !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d expected 0", dc); end
    rst = 1'b0;
    @(negedge clk);
    issue(16'h1234, 16'h1111, 4'b0101, 1'b0, 1'b1);
    observe(5, bc, dc, dcy);
    vectors++; if ({f, dcy[3:0]} !== {16'h2346, 4'd3}) begin
      miscompares++; $display("FAIL midrst_recover: got %h @%0d expected 2346 @3", f, dcy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; s = 4'h0; m = 1'b0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_chain();
    test_hold();
    test_busy_restart();
    test_overflow();
    test_logic();
    test_equality();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
